// File: rtl/csr_pkg.sv
// Shared definitions for the FP CSR access path: addresses, op/funct3
// encodings, controller state and the captured request payload.
package csr_pkg;

  localparam int unsigned CSR_XLEN   = 32;
  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned FUNCT3_W   = 3;

  localparam logic [CSR_ADDR_W-1:0] CSR_FFLAGS = 12'h001;
  localparam logic [CSR_ADDR_W-1:0] CSR_FRM    = 12'h002;
  localparam logic [CSR_ADDR_W-1:0] CSR_FCSR   = 12'h003;

  // Register-file operation applied to the selected CSR
  typedef enum logic [1:0] {
    CSR_OP_RW = 2'b00,
    CSR_OP_RS = 2'b01,
    CSR_OP_RC = 2'b10
  } csr_op_e;

  localparam logic [FUNCT3_W-1:0] F3_CSRRW  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_CSRRS  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_CSRRC  = 3'b011;
  localparam logic [FUNCT3_W-1:0] F3_CSRRWI = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_CSRRSI = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } csr_state_e;

  typedef struct packed {
    logic [FUNCT3_W-1:0]   funct3;
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_XLEN-1:0]   rs1_data;
    logic [REG_IDX_W-1:0]  rs1_idx;
    logic [REG_IDX_W-1:0]  rd_idx;
  } csr_req_t;

  // True for the three CSRs implemented by the FP register file
  function automatic logic csr_addr_supported(input logic [CSR_ADDR_W-1:0] addr);
    return (addr == CSR_FFLAGS) || (addr == CSR_FRM) || (addr == CSR_FCSR);
  endfunction

endpackage

// File: rtl/csr_access_ctrl.sv
// Initiator for FP CSR accesses: accepts one decoded CSR instruction, waits
// for in-flight FPU ops to drain, performs a single register-file access
// cycle and returns the old CSR value to writeback.
// Build option: define CSR_ILLEGAL_TRAP_EN to flag accesses to unsupported
// addresses and non-CSR funct3 values as illegal without touching the
// register file.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = CSR_XLEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [2:0]            i_req_funct3,
  input  logic [11:0]           i_req_addr,
  input  logic [XLEN-1:0]       i_req_rs1_data,
  input  logic [4:0]            i_req_rs1_idx,
  input  logic [4:0]            i_req_rd_idx,
  input  logic                  i_fpu_busy,
  output logic                  o_busy,
  output logic [11:0]           o_csr_addr,
  output logic [1:0]            o_csr_op,
  output logic                  o_csr_write,
  output logic [XLEN-1:0]       o_csr_wr_data,
  input  logic [XLEN-1:0]       i_csr_rd_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [4:0]            o_rsp_rd_idx,
  output logic                  o_rsp_rd_we,
  output logic [XLEN-1:0]       o_rsp_data,
  output logic                  o_rsp_illegal
);

  csr_state_e state_q;
  csr_state_e state_d;
  csr_req_t   req_q;

  logic accept;
  logic no_access_c;
  logic illegal_c;

  // Status outputs are plain decodes of the state register
  assign o_req_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_rsp_valid = (state_q == ST_RESP);
  assign accept      = i_req_valid && o_req_ready;

  // Requests that skip the register-file access entirely
`ifdef CSR_ILLEGAL_TRAP_EN
  assign no_access_c = (i_req_funct3[1:0] == 2'b00) || !csr_addr_supported(i_req_addr);
  assign illegal_c   = no_access_c;
`else
  assign no_access_c = (i_req_funct3[1:0] == 2'b00);
  assign illegal_c   = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and register-file port drive (port is only live in ACCESS)
  always_comb begin
    state_d       = state_q;
    o_csr_addr    = '0;
    o_csr_op      = '0;
    o_csr_write   = 1'b0;
    o_csr_wr_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (no_access_c) begin
            state_d = ST_RESP;
          end else if (i_fpu_busy) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_DRAIN: begin
        if (!i_fpu_busy) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d       = ST_RESP;
        o_csr_addr    = req_q.addr;
        o_csr_op      = 2'(req_q.funct3[1:0] - 2'd1);
        o_csr_wr_data = req_q.funct3[2] ? XLEN'(req_q.rs1_idx) : XLEN'(req_q.rs1_data);
        o_csr_write   = (req_q.funct3[1:0] == 2'b01) || (req_q.rs1_idx != 5'd0);
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the whole request on the accept edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.funct3   <= i_req_funct3;
      req_q.addr     <= i_req_addr;
      req_q.rs1_data <= CSR_XLEN'(i_req_rs1_data);
      req_q.rs1_idx  <= i_req_rs1_idx;
      req_q.rd_idx   <= i_req_rd_idx;
    end
  end

  logic rsp_illegal_q;

  // Response payload: loaded at accept for skipped requests, at the end of
  // the access cycle otherwise, and cleared once writeback takes it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_data    <= '0;
      o_rsp_rd_we   <= 1'b0;
      o_rsp_rd_idx  <= '0;
      rsp_illegal_q <= 1'b0;
    end else if (accept && no_access_c) begin
      o_rsp_data    <= '0;
      o_rsp_rd_we   <= 1'b0;
      o_rsp_rd_idx  <= i_req_rd_idx;
      rsp_illegal_q <= illegal_c;
    end else if (state_q == ST_ACCESS) begin
      o_rsp_data    <= i_csr_rd_data;
      o_rsp_rd_we   <= (req_q.rd_idx != 5'd0);
      o_rsp_rd_idx  <= req_q.rd_idx;
      rsp_illegal_q <= 1'b0;
    end else if ((state_q == ST_RESP) && i_rsp_ready) begin
      o_rsp_data    <= '0;
      o_rsp_rd_we   <= 1'b0;
      o_rsp_rd_idx  <= '0;
      rsp_illegal_q <= 1'b0;
    end
  end

`ifdef CSR_ILLEGAL_TRAP_EN
  assign o_rsp_illegal = rsp_illegal_q;
`else
  assign o_rsp_illegal = 1'b0;
  logic unused_illegal;
  assign unused_illegal = rsp_illegal_q ^ illegal_c;
`endif

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed scoreboard bench for csr_access_ctrl with a small FCSR register
// file model (fflags[4:0], frm[2:0]) on the CSR port.
module tb_csr_access_ctrl;
  import csr_pkg::*;

`ifdef CSR_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rs1_idx;
  logic [4:0]  req_rd_idx;
  logic        fpu_busy;
  logic        busy;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_write;
  logic [31:0] csr_wr_data;
  logic [31:0] csr_rd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_idx;
  logic        rsp_rd_we;
  logic [31:0] rsp_data;
  logic        rsp_illegal;

  always #5 clk = ~clk;

  csr_access_ctrl #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_funct3(req_funct3), .i_req_addr(req_addr),
    .i_req_rs1_data(req_rs1_data), .i_req_rs1_idx(req_rs1_idx),
    .i_req_rd_idx(req_rd_idx), .i_fpu_busy(fpu_busy), .o_busy(busy),
    .o_csr_addr(csr_addr), .o_csr_op(csr_op), .o_csr_write(csr_write),
    .o_csr_wr_data(csr_wr_data), .i_csr_rd_data(csr_rd_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rd_idx(rsp_rd_idx), .o_rsp_rd_we(rsp_rd_we),
    .o_rsp_data(rsp_data), .o_rsp_illegal(rsp_illegal)
  );

  // FCSR register file model: combinational read, write at the clock edge
  logic [4:0] m_fflags;
  logic [2:0] m_frm;

  always_comb begin
    case (csr_addr)
      CSR_FFLAGS: csr_rd_data = {27'd0, m_fflags};
      CSR_FRM:    csr_rd_data = {29'd0, m_frm};
      CSR_FCSR:   csr_rd_data = {24'd0, m_frm, m_fflags};
      default:    csr_rd_data = 32'd0;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] nv;
    if (!rst_n) begin
      m_fflags <= 5'd0;
      m_frm    <= 3'd0;
    end else if (csr_write) begin
      case (csr_op)
        2'b00:   nv = csr_wr_data;
        2'b01:   nv = csr_rd_data | csr_wr_data;
        default: nv = csr_rd_data & ~csr_wr_data;
      endcase
      case (csr_addr)
        CSR_FFLAGS: m_fflags <= nv[4:0];
        CSR_FRM:    m_frm    <= nv[2:0];
        CSR_FCSR:   begin m_fflags <= nv[4:0]; m_frm <= nv[7:5]; end
        default:    ;
      endcase
    end
  end

  typedef struct {
    bit          acc;
    logic [11:0] addr;
    logic [1:0]  op;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] data;
    logic        we;
    logic [4:0]  rd;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endfunction

  function automatic exp_t mk(input bit acc, input logic [11:0] addr, input logic [1:0] op,
                              input logic wr, input logic [31:0] wd, input logic [31:0] data,
                              input logic we, input logic [4:0] rd, input logic ill, input int lat);
    exp_t e;
    e.acc = acc; e.addr = addr; e.op = op; e.wr = wr; e.wd = wd;
    e.data = data; e.we = we; e.rd = rd; e.ill = ill; e.lat = lat;
    return e;
  endfunction

  // Monitor: observes access cycles and responses at the falling edge
  int          ncyc = 0;
  int          acc_at = 0;
  int          v_cyc = 0;
  int          acc_cnt = 0;
  bit          snap_v = 1'b0;
  logic [11:0] a_addr;
  logic [1:0]  a_op;
  logic        a_wr;
  logic [31:0] a_wd;
  logic [31:0] s_data;
  logic        s_we;
  logic [4:0]  s_rd;
  logic        s_ill;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      acc_cnt = 0;
      snap_v  = 1'b0;
    end else begin
      ncyc++;
      if (csr_addr != 12'd0 || csr_write) begin
        acc_cnt++;
        a_addr = csr_addr; a_op = csr_op; a_wr = csr_write; a_wd = csr_wr_data;
        if (exp_q.size() == 0) fail("spurious_access");
      end
      if (rsp_valid) begin
        if (!snap_v) begin
          snap_v = 1'b1; v_cyc = ncyc;
          s_data = rsp_data; s_we = rsp_rd_we; s_rd = rsp_rd_idx; s_ill = rsp_illegal;
        end else begin
          chk("stall_data", rsp_data, s_data);
          chk("stall_we", 32'(rsp_rd_we), 32'(s_we));
          chk("stall_rd", 32'(rsp_rd_idx), 32'(s_rd));
          chk("stall_ill", 32'(rsp_illegal), 32'(s_ill));
        end
        if (!rsp_ready) begin
          chk("req_ready_in_stall", 32'(req_ready), 32'd0);
        end else begin
          if (exp_q.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            e = exp_q.pop_front();
            chk("access_count", 32'(acc_cnt), e.acc ? 32'd1 : 32'd0);
            if (e.acc && acc_cnt == 1) begin
              chk("csr_addr", 32'(a_addr), 32'(e.addr));
              chk("csr_op", 32'(a_op), 32'(e.op));
              chk("csr_write", 32'(a_wr), 32'(e.wr));
              chk("csr_wr_data", a_wd, e.wd);
            end
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_rd_we", 32'(rsp_rd_we), 32'(e.we));
            chk("rsp_rd_idx", 32'(rsp_rd_idx), 32'(e.rd));
            chk("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
            if (e.lat != 0) chk("latency", 32'(v_cyc - acc_at), 32'(e.lat));
          end
          snap_v  = 1'b0;
          acc_cnt = 0;
        end
      end
      if (req_valid && req_ready) acc_at = ncyc;
    end
  end

  // Present one request and hold it until it is accepted
  task automatic send(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] d,
                      input logic [4:0] rs1, input logic [4:0] rd);
    int t = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = f3; req_addr = addr;
    req_rs1_data = d; req_rs1_idx = rs1; req_rd_idx = rd;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      t++;
      if (t > 100) begin fail("accept_timeout"); break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && req_ready) break;
      t++;
      if (t > 200) begin fail("idle_timeout"); break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
    req_rs1_data = '0; req_rs1_idx = '0; req_rd_idx = '0;
    fpu_busy = 1'b0; rsp_ready = 1'b1;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_csr_write", 32'(csr_write), 32'd0);
    chk("rst_csr_addr", 32'(csr_addr), 32'd0);
    chk("rst_csr_op", 32'(csr_op), 32'd0);
    chk("rst_csr_wr_data", csr_wr_data, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_we", 32'(rsp_rd_we), 32'd0);
    chk("rst_rsp_rd", 32'(rsp_rd_idx), 32'd0);
    chk("rst_rsp_ill", 32'(rsp_illegal), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset while draining: no access, no response
    fpu_busy = 1'b1;
    send(F3_CSRRW, CSR_FFLAGS, 32'h1F, 5'd1, 5'd1);
    @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_req_ready", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_csr_write", 32'(csr_write), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    fpu_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // CSRRW fflags <- 0x05
    exp_q.push_back(mk(1, CSR_FFLAGS, CSR_OP_RW, 1, 32'h05, 32'h0, 0, 5'd0, 0, 2));
    send(F3_CSRRW, CSR_FFLAGS, 32'h05, 5'd4, 5'd0);
    wait_idle();
    chk("fflags_after_rw", 32'(m_fflags), 32'h05);

    // CSRRS fflags, rs1=x2 (0x1A), rd=x3
    exp_q.push_back(mk(1, CSR_FFLAGS, CSR_OP_RS, 1, 32'h1A, 32'h05, 1, 5'd3, 0, 2));
    send(F3_CSRRS, CSR_FFLAGS, 32'h1A, 5'd2, 5'd3);
    wait_idle();
    chk("fflags_after_rs", 32'(m_fflags), 32'h1F);

    // CSRRCI fcsr zimm=0, rd=x0: read-only, no write
    exp_q.push_back(mk(1, CSR_FCSR, CSR_OP_RC, 0, 32'h0, 32'h1F, 0, 5'd0, 0, 2));
    send(F3_CSRRCI, CSR_FCSR, 32'hDEAD_BEEF, 5'd0, 5'd0);
    wait_idle();

    // CSRRWI frm zimm=3 with the FPU busy for four cycles
    exp_q.push_back(mk(1, CSR_FRM, CSR_OP_RW, 1, 32'h3, 32'h0, 1, 5'd5, 0, 0));
    fpu_busy = 1'b1;
    send(F3_CSRRWI, CSR_FRM, 32'h0, 5'd3, 5'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_no_write", 32'(csr_write), 32'd0);
      chk("drain_no_addr", 32'(csr_addr), 32'd0);
      chk("drain_o_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1 fpu_busy = 1'b0;
    wait_idle();
    chk("frm_after_rwi", 32'(m_frm), 32'h3);

    // CSRRS fcsr rs1=x0 (pure read) with writeback stalled five cycles
    exp_q.push_back(mk(1, CSR_FCSR, CSR_OP_RS, 0, 32'hFFFF_FFFF, 32'h7F, 1, 5'd7, 0, 2));
    rsp_ready = 1'b0;
    send(F3_CSRRS, CSR_FCSR, 32'hFFFF_FFFF, 5'd0, 5'd7);
    repeat (4) @(posedge clk);
    #1 rsp_ready = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) break;
      t++;
      if (t > 50) begin fail("stall_rsp_timeout"); break; end
    end
    @(negedge clk);
    chk("ready_after_hs", 32'(req_ready), 32'd1);
    chk("valid_after_hs", 32'(rsp_valid), 32'd0);
    wait_idle();

    // funct3 = 000 is not a CSR op
    exp_q.push_back(mk(0, 12'h0, 2'b00, 0, 32'h0, 32'h0, 0, 5'd9, TRAP, 1));
    send(3'b000, CSR_FFLAGS, 32'h12, 5'd2, 5'd9);
    wait_idle();

    // CSRRW to an unsupported address
    if (TRAP)
      exp_q.push_back(mk(0, 12'h0, 2'b00, 0, 32'h0, 32'h0, 0, 5'd8, 1, 1));
    else
      exp_q.push_back(mk(1, 12'h300, CSR_OP_RW, 1, 32'h55, 32'h0, 1, 5'd8, 0, 2));
    send(F3_CSRRW, 12'h300, 32'h55, 5'd6, 5'd8);
    wait_idle();
    chk("fflags_untouched", 32'(m_fflags), 32'h1F);

    // Back-to-back: CSRRC fflags (clear 0x03), then CSRRSI frm zimm=4
    exp_q.push_back(mk(1, CSR_FFLAGS, CSR_OP_RC, 1, 32'h03, 32'h1F, 1, 5'd2, 0, 2));
    exp_q.push_back(mk(1, CSR_FRM, CSR_OP_RS, 1, 32'h4, 32'h3, 1, 5'd10, 0, 2));
    send(F3_CSRRC, CSR_FFLAGS, 32'h03, 5'd1, 5'd2);
    send(F3_CSRRSI, CSR_FRM, 32'h0, 5'd4, 5'd10);
    wait_idle();
    chk("fflags_after_rc", 32'(m_fflags), 32'h1C);
    chk("frm_after_rsi", 32'(m_frm), 32'h7);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
